// File: rtl/nes_clk_pkg.sv
// Shared constants and state type for the NES clock-enable sequencer.
// Phase indices and divider ratios are expressed relative to the 21.477 MHz master clock.
package nes_clk_pkg;

    localparam int CPU_DIV = 12;
    localparam int PPU_DIV = 4;
    localparam int M2_RISE = 5;
    localparam int PHASE_W = 4;

    typedef enum logic [1:0] {
        LOCKWAIT = 2'd0,
        HOLD     = 2'd1,
        RUN      = 2'd2,
        PAUSED   = 2'd3
    } ce_state_t;

    function automatic logic is_ppu_phase(input logic [PHASE_W-1:0] p);
        return (p == PHASE_W'(0)) || (p == PHASE_W'(PPU_DIV)) || (p == PHASE_W'(2 * PPU_DIV));
    endfunction

endpackage

// File: rtl/nes_clock_enables_sync2.sv
// Generic two-flop synchroniser with asynchronous clear.
// Used to bring the PLL lock flag into the master clock domain.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/nes_clock_enables.sv
// Reset sequencer and phase-aligned CPU/PPU/M2 clock enables for the NES core.
// state    | meaning
// LOCKWAIT | core held in reset until the synchronised PLL lock is seen
// HOLD     | lock seen, core reset held for RESET_CYCLES master cycles
// RUN      | phase counter running, enables generated
// PAUSED   | frozen on a CPU-cycle boundary, phase parked at 0
module nes_clock_enables
    import nes_clk_pkg::*;
#(
    parameter int RESET_CYCLES = 1024,
    parameter int COUNT_W      = 16
) (
    input  logic               clock21,
    input  logic               reset,
    input  logic               clock_locked,
    input  logic               pause_req,
    output logic               sys_reset,
    output logic               cpu_ce,
    output logic               ppu_ce,
    output logic               m2,
    output logic [3:0]         phase,
    output logic               paused,
    output logic [COUNT_W-1:0] cpu_count
);

    localparam int HOLD_W = $clog2(RESET_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CPU_DIV - 1);

    ce_state_t           r_state, w_state_nxt;
    logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
    logic [PHASE_W-1:0]  r_phase, w_phase_nxt, w_phase_inc;
    logic                r_sys_reset, w_sys_reset_nxt;
    logic                r_cpu_ce, w_cpu_ce_nxt;
    logic                r_ppu_ce, w_ppu_ce_nxt;
    logic                r_m2, w_m2_nxt;
    logic                r_paused, w_paused_nxt;
    logic [COUNT_W-1:0]  r_cpu_count, w_cpu_count_nxt;
    logic                w_lock_s;

    sync2 #(.W(1)) u_lock_sync (
        .clk (clock21),
        .rst (reset),
        .d   (clock_locked),
        .q   (w_lock_s)
    );

    assign w_phase_inc = (r_phase == PHASE_LAST) ? '0 : r_phase + 1'b1;

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold;
        w_phase_nxt     = r_phase;
        w_sys_reset_nxt = r_sys_reset;
        w_cpu_ce_nxt    = 1'b0;
        w_ppu_ce_nxt    = 1'b0;
        w_m2_nxt        = 1'b0;
        w_paused_nxt    = 1'b0;

        // Lock loss outranks everything, including a pending pause.
        if (r_state != LOCKWAIT && !w_lock_s) begin
            w_state_nxt     = LOCKWAIT;
            w_sys_reset_nxt = 1'b1;
            w_phase_nxt     = '0;
        end else begin
            case (r_state)
                LOCKWAIT: begin
                    w_sys_reset_nxt = 1'b1;
                    w_phase_nxt     = '0;
                    if (w_lock_s) begin
                        w_state_nxt = HOLD;
                        w_hold_nxt  = '0;
                    end
                end
                HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        w_state_nxt     = RUN;
                        w_sys_reset_nxt = 1'b0;
                        w_phase_nxt     = '0;
                        w_cpu_ce_nxt    = 1'b1;
                        w_ppu_ce_nxt    = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
                RUN: begin
                    if (r_phase == PHASE_LAST && pause_req) begin
                        w_state_nxt  = PAUSED;
                        w_phase_nxt  = '0;
                        w_paused_nxt = 1'b1;
                    end else begin
                        w_phase_nxt  = w_phase_inc;
                        w_cpu_ce_nxt = (w_phase_inc == '0);
                        w_ppu_ce_nxt = is_ppu_phase(w_phase_inc);
                        w_m2_nxt     = (w_phase_inc >= PHASE_W'(M2_RISE));
                    end
                end
                PAUSED: begin
                    w_phase_nxt = '0;
                    if (!pause_req) begin
                        w_state_nxt  = RUN;
                        w_cpu_ce_nxt = 1'b1;
                        w_ppu_ce_nxt = 1'b1;
                    end else begin
                        w_paused_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt     = LOCKWAIT;
                    w_sys_reset_nxt = 1'b1;
                    w_phase_nxt     = '0;
                end
            endcase
        end

        // Clearing on the next sys_reset value makes the count read 0 in the first reset cycle.
        if (w_sys_reset_nxt) begin
            w_cpu_count_nxt = '0;
        end else begin
            w_cpu_count_nxt = r_cpu_count + COUNT_W'(r_cpu_ce);
        end
    end

    always_ff @(posedge clock21 or posedge reset) begin
        if (reset) begin
            r_state     <= LOCKWAIT;
            r_hold      <= '0;
            r_phase     <= '0;
            r_sys_reset <= 1'b1;
            r_cpu_ce    <= 1'b0;
            r_ppu_ce    <= 1'b0;
            r_m2        <= 1'b0;
            r_paused    <= 1'b0;
            r_cpu_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_phase     <= w_phase_nxt;
            r_sys_reset <= w_sys_reset_nxt;
            r_cpu_ce    <= w_cpu_ce_nxt;
            r_ppu_ce    <= w_ppu_ce_nxt;
            r_m2        <= w_m2_nxt;
            r_paused    <= w_paused_nxt;
            r_cpu_count <= w_cpu_count_nxt;
        end
    end

    assign sys_reset = r_sys_reset;
    assign cpu_ce    = r_cpu_ce;
    assign ppu_ce    = r_ppu_ce;
    assign m2        = r_m2;
    assign phase     = r_phase;
    assign paused    = r_paused;
    assign cpu_count = r_cpu_count;

endmodule

// File: tb/tb_nes_clock_enables.sv
// Directed bench for nes_clock_enables: bring-up, cadence, pause, lock loss, reset mid-hold.
// A second instance with a 4-bit count shares the stimulus to exercise counter wrap.
module tb_nes_clock_enables;

    logic        clock21;
    logic        reset;
    logic        clock_locked;
    logic        pause_req;

    logic        sys_reset, cpu_ce, ppu_ce, m2, paused;
    logic [3:0]  phase;
    logic [15:0] cpu_count;

    logic        sys_reset4, cpu_ce4, ppu_ce4, m24, paused4;
    logic [3:0]  phase4;
    logic [3:0]  cpu_count4;

    int checks = 0;
    int errors = 0;

    nes_clock_enables #(.RESET_CYCLES(16), .COUNT_W(16)) dut (
        .clock21      (clock21),
        .reset        (reset),
        .clock_locked (clock_locked),
        .pause_req    (pause_req),
        .sys_reset    (sys_reset),
        .cpu_ce       (cpu_ce),
        .ppu_ce       (ppu_ce),
        .m2           (m2),
        .phase        (phase),
        .paused       (paused),
        .cpu_count    (cpu_count)
    );

    nes_clock_enables #(.RESET_CYCLES(16), .COUNT_W(4)) dut4 (
        .clock21      (clock21),
        .reset        (reset),
        .clock_locked (clock_locked),
        .pause_req    (pause_req),
        .sys_reset    (sys_reset4),
        .cpu_ce       (cpu_ce4),
        .ppu_ce       (ppu_ce4),
        .m2           (m24),
        .phase        (phase4),
        .paused       (paused4),
        .cpu_count    (cpu_count4)
    );

    initial clock21 = 1'b0;
    always #5 clock21 = ~clock21;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock21);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_cpu, n_ppu, n_m2;

        reset        = 1'b1;
        clock_locked = 1'b0;
        pause_req    = 1'b0;
        tick(2);

        check("rst_sys_reset", 32'(sys_reset), 32'd1);
        check("rst_paused",    32'(paused),    32'd0);
        check("rst_m2",        32'(m2),        32'd0);
        check("rst_cpu_ce",    32'(cpu_ce),    32'd0);
        check("rst_ppu_ce",    32'(ppu_ce),    32'd0);
        check("rst_phase",     32'(phase),     32'd0);
        check("rst_cpu_count", 32'(cpu_count), 32'd0);

        reset = 1'b0;
        tick(5);
        check("lockwait_sys_reset", 32'(sys_reset), 32'd1);
        check("lockwait_cpu_ce",    32'(cpu_ce),    32'd0);

        // Bring-up: 2 sync + 1 state + 16 hold cycles.
        clock_locked = 1'b1;
        tick(18);
        check("bringup_still_reset", 32'(sys_reset), 32'd1);
        check("bringup_no_ce",       32'(cpu_ce),    32'd0);
        tick(1);
        check("bringup_sys_reset", 32'(sys_reset), 32'd0);
        check("bringup_cpu_ce",    32'(cpu_ce),    32'd1);
        check("bringup_ppu_ce",    32'(ppu_ce),    32'd1);
        check("bringup_phase",     32'(phase),     32'd0);
        check("bringup_m2",        32'(m2),        32'd0);
        check("bringup_count",     32'(cpu_count), 32'd0);

        // Cadence over 120 RUN cycles.
        n_cpu = 0; n_ppu = 0; n_m2 = 0;
        for (int i = 0; i < 120; i++) begin
            check("cad_phase", 32'(phase), 32'(i % 12));
            check("cad_m2",    32'(m2),    32'((i % 12) >= 5));
            n_cpu += int'(cpu_ce);
            n_ppu += int'(ppu_ce);
            n_m2  += int'(m2);
            tick(1);
        end
        check("cad_cpu_pulses", 32'(n_cpu),     32'd10);
        check("cad_ppu_pulses", 32'(n_ppu),     32'd30);
        check("cad_m2_high",    32'(n_m2),      32'd70);
        check("cad_count",      32'(cpu_count), 32'd10);
        check("cad_count4",     32'(cpu_count4), 32'd10);

        // Narrow counter wraps on its 16th enable.
        tick(60);
        check("wrap_count_15",  32'(cpu_count),  32'd15);
        check("wrap_count4_15", 32'(cpu_count4), 32'd15);
        tick(12);
        check("wrap_count_16",  32'(cpu_count),  32'd16);
        check("wrap_count4_0",  32'(cpu_count4), 32'd0);

        // Pause requested mid-cycle at phase 3.
        tick(3);
        check("pause_req_phase", 32'(phase), 32'd3);
        pause_req = 1'b1;
        tick(8);
        check("pause_wait_phase",  32'(phase),  32'd11);
        check("pause_wait_paused", 32'(paused), 32'd0);
        tick(1);
        check("paused_flag",   32'(paused),    32'd1);
        check("paused_phase",  32'(phase),     32'd0);
        check("paused_cpu_ce", 32'(cpu_ce),    32'd0);
        check("paused_ppu_ce", 32'(ppu_ce),    32'd0);
        check("paused_m2",     32'(m2),        32'd0);
        check("paused_count",  32'(cpu_count), 32'd17);
        tick(5);
        check("paused_hold_flag",  32'(paused),    32'd1);
        check("paused_hold_count", 32'(cpu_count), 32'd17);
        pause_req = 1'b0;
        tick(1);
        check("resume_paused", 32'(paused),    32'd0);
        check("resume_cpu_ce", 32'(cpu_ce),    32'd1);
        check("resume_ppu_ce", 32'(ppu_ce),    32'd1);
        check("resume_phase",  32'(phase),     32'd0);
        check("resume_count",  32'(cpu_count), 32'd17);
        tick(1);
        check("resume_count_next", 32'(cpu_count), 32'd18);
        check("resume_phase_next", 32'(phase),     32'd1);

        // Lock loss in RUN.
        clock_locked = 1'b0;
        tick(2);
        check("droprun_not_yet", 32'(sys_reset), 32'd0);
        tick(1);
        check("droprun_sys_reset", 32'(sys_reset), 32'd1);
        check("droprun_cpu_ce",    32'(cpu_ce),    32'd0);
        check("droprun_ppu_ce",    32'(ppu_ce),    32'd0);
        check("droprun_count",     32'(cpu_count), 32'd0);
        check("droprun_phase",     32'(phase),     32'd0);

        // Relock repeats the full hold.
        tick(4);
        clock_locked = 1'b1;
        tick(18);
        check("relock_still_reset", 32'(sys_reset), 32'd1);
        tick(1);
        check("relock_sys_reset", 32'(sys_reset), 32'd0);
        check("relock_cpu_ce",    32'(cpu_ce),    32'd1);

        // Lock loss while paused.
        pause_req = 1'b1;
        tick(11);
        check("droppause_phase11", 32'(phase), 32'd11);
        tick(1);
        check("droppause_paused", 32'(paused), 32'd1);
        clock_locked = 1'b0;
        tick(2);
        check("droppause_not_yet", 32'(paused), 32'd1);
        tick(1);
        check("droppause_sys_reset", 32'(sys_reset), 32'd1);
        check("droppause_paused_clr", 32'(paused),   32'd0);
        check("droppause_cpu_ce",    32'(cpu_ce),    32'd0);
        check("droppause_count",     32'(cpu_count), 32'd0);
        pause_req = 1'b0;

        // Reset mid-HOLD (hold count 7) restarts the full sequence.
        tick(3);
        clock_locked = 1'b1;
        tick(10);
        check("midhold_sys_reset", 32'(sys_reset), 32'd1);
        reset = 1'b1;
        #1;
        check("midhold_rst_sys_reset", 32'(sys_reset), 32'd1);
        check("midhold_rst_phase",     32'(phase),     32'd0);
        tick(1);
        reset = 1'b0;
        tick(18);
        check("midhold_restart_still", 32'(sys_reset), 32'd1);
        tick(1);
        check("midhold_restart_sys_reset", 32'(sys_reset), 32'd0);
        check("midhold_restart_cpu_ce",    32'(cpu_ce),    32'd1);
        check("midhold_restart_ppu_ce",    32'(ppu_ce),    32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_clock_enables.md
# nes_clock_enables

Clock-enable and reset sequencer driven by the 21.477 MHz master clock and its PLL lock flag. Waits for a stable lock, holds the NES core in reset for a fixed number of master cycles, then produces phase-aligned CPU (÷12), PPU (÷4) and M2 enables. Supports a debug pause that stops cleanly on a CPU-cycle boundary. Sits between the clock generator and the CPU/PPU/APU core; every core register is clocked by `clock21` and qualified by these enables.

## Interface
- `RESET_CYCLES`, 1024: master cycles `sys_reset` stays high after lock is seen; must be ≥ 2.
- `COUNT_W`, 16: width of `cpu_count`.

- `clock21`  in  1  21.477 MHz master clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clock_locked`  in  1  PLL lock flag; treated as asynchronous and double-synchronised.
- `pause_req`  in  1  level request to freeze the core.
- `sys_reset`  out  1  synchronous core reset, active-high.
- `cpu_ce`  out  1  one-cycle CPU enable, 1 in 12 master cycles.
- `ppu_ce`  out  1  one-cycle PPU enable, 1 in 4 master cycles.
- `m2`  out  1  CPU M2 phase level.
- `phase`  out  4  master-cycle index within the CPU cycle, 0..11.
- `paused`  out  1  high while frozen.
- `cpu_count`  out  COUNT_W  CPU cycles since `sys_reset` fell; wraps.

## Operation
- States: LOCKWAIT, HOLD, RUN, PAUSED.
- `lock_s` is `clock_locked` after a 2-flop synchroniser.
- LOCKWAIT: `sys_reset`=1, enables 0. Moves to HOLD when `lock_s`=1 and clears the hold counter.
- HOLD: the counter increments each cycle. When it reaches RESET_CYCLES-1, the state moves to RUN on the next edge.
- RUN entry: `sys_reset`←0, `phase`←0, `cpu_ce`←1, `ppu_ce`←1.
- RUN:
  - `phase` advances 0→11 and wraps to 0.
  - `cpu_ce` = (`phase`==0).
  - `ppu_ce` = (`phase`∈{0,4,8}).
  - `m2` = (`phase`≥5).
  - All outputs are registered, so each is coincident with its `phase` value.
- Pause entry: sampled only in RUN with `phase`==11. If `pause_req`=1 there, the next state is PAUSED with `phase`←0, all enables 0, `m2`=0 and `paused`=1. A request raised mid-cycle waits for the wrap.
- PAUSED exit: when `pause_req`=0, the next edge returns to RUN with RUN-entry values; `cpu_count` is preserved.
- `cpu_count` increments on every cycle with `cpu_ce`=1. It is cleared while `sys_reset`=1 and wraps modulo 2^COUNT_W.
- Lock loss: `lock_s`=0 in HOLD, RUN or PAUSED returns to LOCKWAIT on the next edge, with `sys_reset`←1 and all enables ←0. Lock loss has priority over pause.
- `reset` asserted at any time, mid-HOLD or mid-pause included: immediate return to LOCKWAIT.

## Timing
- Values under `reset`:
  - `sys_reset`=1, `paused`=0, `m2`=0.
  - `cpu_ce`=`ppu_ce`=0, `phase`=0, `cpu_count`=0.
  - Synchroniser flops cleared; state LOCKWAIT.
- `clock_locked` rise to `lock_s` rise: 2 cycles. One more cycle to HOLD.
- `sys_reset` fall occurs RESET_CYCLES cycles after HOLD entry. `cpu_ce`=1 in that same cycle.
- Lock fall to `sys_reset` rise: 3 cycles (2 synchroniser + 1 state).
- Pause latency: `paused` rises on the edge after the first `phase`==11 cycle with `pause_req`=1. Resume is 1 cycle after `pause_req` falls.
- In RUN and PAUSED, `cpu_ce` and `ppu_ce` never assert while `sys_reset`=1.

## Structure
- Shared package `nes_clk_pkg`:
  - constants CPU_DIV=12, PPU_DIV=4, M2_RISE=5;
  - typedef `ce_state_t` {LOCKWAIT, HOLD, RUN, PAUSED}.
- One sub-module, `sync2`: a generic 2-flop synchroniser with async clear, used for `clock_locked`.
- Phase counter, hold counter and FSM stay in the top module.

## Test plan
- Lock bring-up: `reset` pulse, `clock_locked` high at cycle 10, RESET_CYCLES=16 → `sys_reset` falls at cycle 10+3+16; `cpu_ce`=`ppu_ce`=1 in that cycle.
- Run cadence: 120 cycles in RUN → `cpu_ce` pulses 10, `ppu_ce` pulses 30, `m2` high 7 of every 12 cycles, `cpu_count`=10.
- Pause at `phase`=3 → `paused` rises 9 cycles later with `phase`=0 and no enables. Releasing `pause_req` → `cpu_ce`=1 one cycle later; `cpu_count` continues from the held value.
- Lock drop during RUN and during PAUSED → `sys_reset`=1 three cycles later, enables 0, `cpu_count`=0. Relock repeats the full HOLD.
- `reset` asserted mid-HOLD (count 7) → immediate LOCKWAIT. Release with lock held → full RESET_CYCLES hold restarts from 0.
- COUNT_W=4 → `cpu_count` wraps 15→0 on the 16th `cpu_ce`.
